// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states: idle, or one port owning the memory.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    // Port identifiers, used for the round-robin last-grant memory.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/arb_wait_watchdog.sv
// Wait-cycle counter for a busy memory transaction. It is cleared on grant,
// counts while enabled, stops at MAX_WAIT, and flags that terminal count.
module arb_wait_watchdog #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        // NOTE: the default assignment comes first so that no path leaves cnt_d unassigned, which would infer a latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TERM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// (IF) and data access (DM). Requests are granted round-robin, each access runs
// a request/ready handshake with registered responses, and a watchdog aborts
// transactions that never see mem_ready.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_pipe,
    output logic              err_timeout
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              err_q, err_d;

    logic elig_if, elig_dm, grant_if, grant_dm;
    logic wd_clr, wd_en, wd_tc;

    // A port is ignored in its own ack cycle so a held request is not re-granted at once.
    assign elig_if  = if_req & ~if_ack_q;
    assign elig_dm  = dm_req & ~dm_ack_q;
    assign grant_dm = elig_dm & (~elig_if | (last_grant_q == PORT_IF));
    assign grant_if = elig_if & ~grant_dm;

    arb_wait_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .tc_o  (wd_tc)
    );

    // Next-state, grant, completion and abort logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        err_d        = err_q;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d      = DM_BUSY;
                    mem_req_d    = 1'b1;
                    mem_we_d     = dm_we;
                    mem_addr_d   = dm_addr;
                    mem_wdata_d  = dm_wdata;
                    last_grant_d = PORT_DM;
                    wd_clr       = 1'b1;
                end else if (grant_if) begin
                    state_d      = IF_BUSY;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    last_grant_d = PORT_IF;
                    wd_clr       = 1'b1;
                end
            end

            IF_BUSY, DM_BUSY: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_ack_d = 1'b1;
                        // Stores leave the last load data visible.
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                end else if (wd_tc) begin
                    // Hung transaction: release the memory and complete with zero data.
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = '0;
                    end
                end else begin
                    wd_en = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the datapath registers are reset too, because the interface promises all-zero outputs straight out of reset.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            err_q        <= err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_ack      = if_ack_q;
    assign dm_ack      = dm_ack_q;
    assign err_timeout = err_q;

    // Stalls are combinational so the pipeline freezes in the same cycle a request appears.
    assign stall_if   = if_req & ~if_ack_q;
    assign stall_pipe = dm_req & ~dm_ack_q;

endmodule
